// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-line PWM output stage driven by the SPI register file.
// A 16-bit prescaler produces a tick every PRESCALE clk cycles. The tick
// advances an 8-bit period counter, which is compared against the shared
// duty value. Each output line is off, constant high or PWM, depending on
// its enable bits.
// Optional build macro: PWM_DUTY_SHADOW_EN. When it is defined, the duty
// value is latched only at the period boundary, so no runt pulses occur.
// When it is undefined, the duty input is used directly.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_q;
    logic [15:0] pre_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        tick;
    logic        wrap;
    logic [7:0]  duty_eff;
    logic        pwm_sig;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] pwm_d;
    logic [15:0] pwm_out_q;
    logic        period_start_q;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Prescaler / period counter next-state, plus the wrap (period boundary) strobe
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        wrap  = tick && (cnt_q == 8'hFF);
        pre_d = tick ? 16'h0000 : pre_q + 16'h0001;
        cnt_d = tick ? cnt_q + 8'h01 : cnt_q;
    end

    // Counter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= 16'h0000;
            cnt_q <= 8'h00;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_q;

    // Shadow duty: a new value is taken only at the period boundary, so a
    // period always completes with the duty value it started with
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'h00;
        end else if (wrap) begin
            duty_q <= pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // Full scale is forced high so that 0xFF has no low step at cnt == 255
    always_comb begin
        pwm_sig = (duty_eff == 8'hFF) ? 1'b1 : (cnt_q < duty_eff);
    end

    // Per-line mode select: off, constant high, or PWM
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_line
            assign pwm_d[gi] = en_out[gi] & (~en_pwm[gi] | pwm_sig);
        end
    endgenerate

    // Output registers; period_start follows the tick that wrapped cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out_q      <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            pwm_out_q      <= pwm_d;
            period_start_q <= wrap;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Testbench for pwm_peripheral (PRESCALE = 4).
// The reference model works from the number of clk edges since reset release:
//   - The counter value is (edges / P) mod 256.
//   - A period starts at each edge that is a multiple of 256*P.
// It passes with or without PWM_DUTY_SHADOW_EN defined.
module tb_pwm_peripheral;

    localparam int P      = 4;
    localparam int PERIOD = 256 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] pwm_out;
    logic        period_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference-model state.
    int         e = 0;            // clk edges since reset release
    logic [7:0] sh_duty = 8'h00;  // duty value adopted at the last period start

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .pwm_out         (pwm_out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_cnt(input int edges);
        return (edges / P) % 256;
    endfunction

    // Advance one clk edge and check both outputs against the model.
    task automatic step();
        logic [7:0]  d_eff;
        logic        sig;
        logic [15:0] exp_o;
        logic        exp_ps;
`ifdef PWM_DUTY_SHADOW_EN
        d_eff = sh_duty;
`else
        d_eff = duty;
`endif
        sig    = (d_eff == 8'hFF) ? 1'b1 : (m_cnt(e) < int'(d_eff));
        exp_o  = en_out & (~en_pwm | {16{sig}});
        exp_ps = ((e + 1) % PERIOD) == 0;
        if (exp_ps) sh_duty = duty;
        @(posedge clk);
        #1;
        e++;
        check_val("pwm_out", {16'h0, pwm_out}, {16'h0, exp_o});
        check_val("period_start", {31'h0, period_start}, {31'h0, exp_ps});
    endtask

    task automatic wait_period_start();
        bit seen = 0;
        for (int i = 0; i < PERIOD + 16 && !seen; i++) begin
            step();
            if (period_start) seen = 1;
        end
        check_val("period_start_timeout", {31'h0, seen}, 32'h1);
    endtask

    // Count the high samples of one line over one full period, starting at a period boundary.
    task automatic measure_period(input int bit_idx, output int highs);
        wait_period_start();
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            if (pwm_out[bit_idx]) highs++;
        end
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_out = eo;
        en_pwm = ep;
        duty   = d;
        $display("cfg: en_out=%h en_pwm=%h duty=%h cnt=%0d", eo, ep, d, m_cnt(e));
    endtask

    initial begin
        int highs;
        int pulses;
        bit found;

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_pwm_out", {16'h0, pwm_out}, 32'h0);
        check_val("reset_period_start", {31'h0, period_start}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        sh_duty = 8'h00;

        // All enables off: the outputs stay low and period_start pulses every 1024 cycles.
        set_cfg(16'h0000, 16'h0000, 8'h80);
        pulses = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            if (period_start) pulses++;
        end
        check_val("period_start_count", pulses, 2);

        // All lines on, in constant-high mode.
        set_cfg(16'hFFFF, 16'h0000, 8'h80);
        step();
        check_val("const_high", {16'h0, pwm_out}, 32'h0000FFFF);
        repeat (20) step();

        // Bit 0 at duty 0x40 is high for 256 of every 1024 cycles.
        set_cfg(16'h0001, 16'h0001, 8'h40);
        measure_period(0, highs);
        check_val("duty40_highs", highs, 256);

        // Bit 15 at duty 0x00 is constantly low; at duty 0xFF it is constantly high.
        set_cfg(16'h8000, 16'h8000, 8'h00);
        measure_period(15, highs);
        check_val("duty00_highs", highs, 0);
        set_cfg(16'h8000, 16'h8000, 8'hFF);
        measure_period(15, highs);
        check_val("dutyFF_highs", highs, PERIOD);

        // Duty changes from 0x20 to 0xC0 at cnt = 0x50.
        set_cfg(16'h0001, 16'h0001, 8'h20);
        wait_period_start();
        found = 0;
        for (int i = 0; i < PERIOD && !found; i++) begin
            if (m_cnt(e) == 8'h50 && (e % P) == 0) found = 1;
            else step();
        end
        check_val("cnt50_timeout", {31'h0, found}, 32'h1);
        set_cfg(16'h0001, 16'h0001, 8'hC0);
        step();
`ifdef PWM_DUTY_SHADOW_EN
        check_val("duty_change_bit0", {31'h0, pwm_out[0]}, 32'h0);
`else
        check_val("duty_change_bit0", {31'h0, pwm_out[0]}, 32'h1);
`endif
        wait_period_start();
        repeat (PERIOD / 2) step();

        // Randomized configurations, each held for a random time.
        for (int t = 0; t < 24; t++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            d = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            set_cfg(16'($urandom), 16'($urandom), d);
            repeat ($urandom_range(50, 700)) step();
        end

        // Asynchronous reset in the middle of a period, while the outputs are high.
        set_cfg(16'hFFFF, 16'h0000, 8'h80);
        repeat (300) step();
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_pwm_out", {16'h0, pwm_out}, 32'h0);
        check_val("async_reset_period_start", {31'h0, period_start}, 32'h0);
        set_cfg(16'h0001, 16'h0001, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        check_val("held_reset_pwm_out", {16'h0, pwm_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        sh_duty = 8'h00;
        repeat (2 * PERIOD + 50) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Generates 16 PWM-capable output lines from the register set written by the SPI register-write slave. It consumes the five configuration bytes (output enables, PWM enables and a shared duty cycle), runs a prescaled 8-bit period counter and drives the chip's `uo_out[7:0]` and `uio_out[7:0]` pins. It sits directly downstream of the SPI register file, in the same `clk` domain, so no synchronisation is required on its inputs.

## Interface
Parameters:
- `PRESCALE`, default 13: `clk` cycles per PWM counter step, legal range 1..65535. Default gives about 3 kHz PWM at a 10 MHz `clk`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en_reg_out_7_0`  in  8  output enable for `pwm_out[7:0]`.
- `en_reg_out_15_8`  in  8  output enable for `pwm_out[15:8]`.
- `en_reg_pwm_7_0`  in  8  PWM mode select for `pwm_out[7:0]`.
- `en_reg_pwm_15_8`  in  8  PWM mode select for `pwm_out[15:8]`.
- `pwm_duty_cycle`  in  8  shared duty cycle; 0x00 = 0%, 0xFF = 100%.
- `pwm_out`  out  16  `[7:0]` go to `uo_out`, `[15:8]` go to `uio_out`.
- `period_start`  out  1  one-cycle pulse at every PWM period start.

## Operation
Prescaler:
- 16-bit counter `pre` counts 0..PRESCALE-1, then wraps to 0.
- `tick` is asserted in the cycle where `pre == PRESCALE-1`.
- With PRESCALE=1, `tick` is high every cycle.

Period counter:
- 8-bit `cnt` increments on `tick`.
- 255 wraps to 0 on `tick`; this is the period boundary.

Compare:
- `duty_eff` is the effective duty value (see Configuration).
- `pwm_sig` = 1 when `duty_eff == 8'hFF`; otherwise `pwm_sig = (cnt < duty_eff)`.
- Resulting high time is `duty_eff` of every 256 counter steps.
- 0x00 gives constant low; 0xFF gives constant high. There is no 255/256 glitch.

Per-bit output (i = 0..15, using `en_out` = {`en_reg_out_15_8`, `en_reg_out_7_0`} and `en_pwm` likewise):
- `en_out[i]==0` -> 0.
- `en_out[i]==1`, `en_pwm[i]==0` -> constant 1.
- `en_out[i]==1`, `en_pwm[i]==1` -> `pwm_sig`.

Output registering:
- `pwm_out` and `period_start` are registered.
- `period_start` is asserted in the cycle after the `tick` that wrapped `cnt` 255->0.

## Timing
Reset (async assert, sync use after release):
- `pre`=0, `cnt`=0, `duty_eff` register=0, `pwm_out`=16'h0000, `period_start`=0.

Latency:
- Any input change reaches `pwm_out` after exactly 1 `clk` edge. Exception: duty in shadow mode (see Configuration).
- Enable changes always apply mid-period with 1-cycle latency; they are not held to the period boundary.
- `cnt` value N is reflected on `pwm_out` one cycle after `cnt` becomes N.

Period:
- One period is 256 × PRESCALE `clk` cycles.
- `period_start` pulses exactly once per period and never twice in a row. The exception is PRESCALE=1, where it pulses every 256 cycles.

Reset mid-operation:
- All state returns to reset values immediately.
- After release, the first `tick` occurs PRESCALE cycles later.

Simultaneous events:
- A duty write on the same cycle as the wrap `tick` is captured for the new period in shadow mode.

## Configuration
Macro: `PWM_DUTY_SHADOW_EN`.

Defined (shadow mode):
- `duty_eff` is a register loaded from `pwm_duty_cycle` only on the wrap `tick` (`cnt` 255->0).
- Duty changes take effect at the next period start, so no partial or runt pulses occur.
- After reset, the first period runs with duty 0. PWM-mode outputs stay low until the first `period_start`.

Undefined (direct mode):
- `duty_eff = pwm_duty_cycle` combinationally.
- Duty changes apply with 1-cycle latency, mid-period.
- The shadow register is not built.

## Test plan
All tests use PRESCALE=4.
- Reset, then all enables 0, duty 0x80 -> `pwm_out`=0x0000 throughout; `period_start` pulses every 1024 cycles.
- `en_out`=0xFFFF, `en_pwm`=0x0000 -> `pwm_out`=0xFFFF one cycle after the enables are written, held constant.
- `en_out`=`en_pwm`=0x0001, duty 0x40 -> bit0 high for exactly 256 of 1024 cycles per period; rising edge one cycle after `period_start`-aligned `cnt`=0.
- Duty 0x00 then 0xFF on bit 15 with `en_out`=`en_pwm`=0x8000 -> constant 0, then constant 1; no single-cycle low at `cnt`=255.
- With `PWM_DUTY_SHADOW_EN`: duty changed 0x20->0xC0 at `cnt`=0x50 -> the current period keeps its 0x20 high time; 0xC0 high time starts in the cycle after the next `period_start`. Without the macro: the output goes high one cycle after the write.
- Assert `rst_n` low mid-period with outputs high -> `pwm_out`=0 immediately (async); after release, `cnt` advances after 4 cycles.
